// File: rtl/flappy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flappy_pkg                                                           |
// | Shared types, field offsets and layout constants for the pipe and    |
// | coin scheduler.                                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package flappy_pkg;

  // Scheduler control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_t;

  // Pipe word layout: [9:0] top height, [19:10] x, [27:20] gap, [31:28] zero
  localparam int PIPE_H_LSB   = 0;
  localparam int PIPE_X_LSB   = 10;
  localparam int PIPE_GAP_LSB = 20;

  // Coin word layout: [9:0] x, [19:10] y, [30:20] zero, [31] visible
  localparam int COIN_X_LSB   = 0;
  localparam int COIN_Y_LSB   = 10;
  localparam int COIN_VIS_BIT = 31;

  // Layout constants
  localparam logic [9:0]  H_BASE    = 10'd60;
  localparam logic [9:0]  H_LIMIT   = 10'd440;
  localparam logic [9:0]  X_START   = 10'd448;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Top-pipe height from a random byte; the opening must end by H_LIMIT
  function automatic logic [9:0] new_height(input logic [7:0] rnd,
                                            input logic [7:0] gap);
    logic [9:0] h;
    h = H_BASE + {2'b00, rnd};
    if ((h + {2'b00, gap}) > H_LIMIT) begin
      h = H_LIMIT - {2'b00, gap};
    end
    return h;
  endfunction

  function automatic logic [31:0] pack_pipe(input logic [9:0] h,
                                            input logic [9:0] x,
                                            input logic [7:0] gap);
    logic [31:0] word;
    word = '0;
    word[PIPE_H_LSB +: 10]  = h;
    word[PIPE_X_LSB +: 10]  = x;
    word[PIPE_GAP_LSB +: 8] = gap;
    return word;
  endfunction

  function automatic logic [31:0] pack_coin(input logic [9:0] x,
                                            input logic [9:0] y,
                                            input logic       vis);
    logic [31:0] word;
    word = '0;
    word[COIN_X_LSB +: 10] = x;
    word[COIN_Y_LSB +: 10] = y;
    word[COIN_VIS_BIT]     = vis;
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_scheduler_lfsr16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr16                                                               |
// | Free-running 16-bit LFSR, taps 16,14,13,11, right-shifting.          |
// | A non-zero seed keeps it off the all-zero lock-up state.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lfsr16
  import flappy_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic w_fb;

  assign w_fb = q[0] ^ q[2] ^ q[3] ^ q[5];

  // Advance every clock regardless of scheduler state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= {w_fb, q[15:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_scheduler                                                       |
// | Three-slot scrolling pipe layout with coin spawning and score pulse. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int STEP    = 2,
  parameter int SPACING = 224,
  parameter int PIPE_W  = 50,
  parameter int BIRD_X  = 70
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run,
  input  logic        frame_tick,
  input  logic [7:0]  gap_cfg,
  input  logic        coin_taken,
  output logic [31:0] pipe_1,
  output logic [31:0] pipe_2,
  output logic [31:0] pipe_3,
  output logic [31:0] coin,
  output logic        score_tick
);

  localparam int          NUM_SLOTS = 3;
  localparam logic [9:0]  c_step    = 10'(STEP);
  localparam logic [9:0]  c_wrap    = 10'(3 * SPACING - STEP);
  localparam logic [10:0] c_pipe_w  = 11'(PIPE_W);
  localparam logic [10:0] c_bird_x  = 11'(BIRD_X);
  localparam logic [9:0]  c_coin_dx = 10'd17;
  localparam logic [9:0]  c_coin_dy = 10'd8;

  sched_state_t r_state;
  sched_state_t w_next_state;
  logic [1:0]   r_init_cnt;

  logic [15:0]  w_lfsr;
  logic         w_unused_lfsr;

  logic [NUM_SLOTS-1:0][9:0] r_x;
  logic [NUM_SLOTS-1:0][9:0] r_h;
  logic [NUM_SLOTS-1:0][7:0] r_gap;
  logic [NUM_SLOTS-1:0][9:0] w_next_x;
  logic [NUM_SLOTS-1:0]      w_due;
  logic [NUM_SLOTS-1:0]      w_pick;
  logic [NUM_SLOTS-1:0]      w_cross;

  logic [9:0] r_coin_x;
  logic [9:0] r_coin_y;
  logic       r_coin_vis;
  logic       r_score;

  logic       w_advance;
  logic       w_recycle;
  logic [9:0] w_new_h;
  logic [9:0] w_spawn_x;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  // Only the low nine LFSR bits feed the layout
  assign w_unused_lfsr = &{1'b0, w_lfsr[15:9]};

  assign w_new_h   = new_height(w_lfsr[7:0], gap_cfg);
  assign w_advance = (r_state == ST_RUN) && frame_tick && !start;

  // A slot is due for recycling once another step would underflow it;
  // only the lowest-index due slot recycles this frame
  assign w_due[0]  = (r_x[0] < c_step);
  assign w_due[1]  = (r_x[1] < c_step);
  assign w_due[2]  = (r_x[2] < c_step);
  assign w_pick[0] = w_due[0];
  assign w_pick[1] = w_due[1] & ~w_due[0];
  assign w_pick[2] = w_due[2] & ~w_due[1] & ~w_due[0];
  assign w_recycle = |w_pick;

  // Next-state selection; start overrides everything
  always_comb begin
    w_next_state = r_state;
    if (start) begin
      w_next_state = ST_INIT;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = ST_IDLE;
        ST_INIT: if (r_init_cnt == 2'd2) w_next_state = ST_RUN;
        ST_RUN:  if (!run) w_next_state = ST_HOLD;
        ST_HOLD: if (run) w_next_state = ST_RUN;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Per-slot next x on a frame and the pipe-clears-bird detection
  always_comb begin
    w_next_x  = r_x;
    w_cross   = '0;
    w_spawn_x = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (w_pick[k]) begin
        w_next_x[k] = r_x[k] + c_wrap;
        w_spawn_x   = r_x[k] + c_wrap + c_coin_dx;
      end else if (w_due[k]) begin
        // Waiting behind a lower slot: park until the next frame
        w_next_x[k] = r_x[k];
      end else begin
        w_next_x[k] = r_x[k] - c_step;
      end
      w_cross[k] = (({1'b0, r_x[k]} + c_pipe_w) >= c_bird_x) &&
                   (({1'b0, w_next_x[k]} + c_pipe_w) < c_bird_x);
    end
  end

  // State register and the INIT slot counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_init_cnt <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if (start) begin
        r_init_cnt <= 2'd0;
      end else if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 2'd1;
      end
    end
  end

  // Slot registers: one slot loaded per INIT cycle, then scrolled per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_h   <= '0;
      r_gap <= '0;
    end else if (!start) begin
      if (r_state == ST_INIT) begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          if (r_init_cnt == 2'(k)) begin
            r_x[k]   <= 10'(int'(X_START) + k * SPACING);
            r_h[k]   <= w_new_h;
            r_gap[k] <= gap_cfg;
          end
        end
      end else if (w_advance) begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          r_x[k] <= w_next_x[k];
          if (w_pick[k]) begin
            r_h[k]   <= w_new_h;
            r_gap[k] <= gap_cfg;
          end
        end
      end
    end
  end

  // Single-cycle score pulse; several crossings in one frame count once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= 1'b0;
    end else begin
      r_score <= w_advance && (|w_cross);
    end
  end

  // Coin: spawned by a recycle (beats a same-cycle pickup), scrolls with pipes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coin_x   <= '0;
      r_coin_y   <= '0;
      r_coin_vis <= 1'b0;
    end else if (!start && (r_state == ST_INIT)) begin
      r_coin_x   <= '0;
      r_coin_y   <= '0;
      r_coin_vis <= 1'b0;
    end else if (w_advance && w_recycle) begin
      r_coin_x   <= w_spawn_x;
      r_coin_y   <= w_new_h + {3'b000, gap_cfg[7:1]} - c_coin_dy;
      r_coin_vis <= w_lfsr[8];
    end else begin
      if (w_advance) begin
        if (r_coin_x < c_step) begin
          r_coin_vis <= 1'b0;
        end else begin
          r_coin_x <= r_coin_x - c_step;
        end
      end
      if (coin_taken) begin
        r_coin_vis <= 1'b0;
      end
    end
  end

  assign pipe_1     = pack_pipe(r_h[0], r_x[0], r_gap[0]);
  assign pipe_2     = pack_pipe(r_h[1], r_x[1], r_gap[1]);
  assign pipe_3     = pack_pipe(r_h[2], r_x[2], r_gap[2]);
  assign coin       = pack_coin(r_coin_x, r_coin_y, r_coin_vis);
  assign score_tick = r_score;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_scheduler                                                    |
// | Directed self-checking bench for pipe_scheduler.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_scheduler;
  import flappy_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        run;
  logic        frame_tick;
  logic [7:0]  gap_cfg;
  logic        coin_taken;
  logic [31:0] pipe_1;
  logic [31:0] pipe_2;
  logic [31:0] pipe_3;
  logic [31:0] coin;
  logic        score_tick;

  int n_vec   = 0;
  int n_err   = 0;
  int n_score = 0;

  logic [15:0] m_lfsr;

  pipe_scheduler #(
    .STEP    (2),
    .SPACING (224),
    .PIPE_W  (50),
    .BIRD_X  (70)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run        (run),
    .frame_tick (frame_tick),
    .gap_cfg    (gap_cfg),
    .coin_taken (coin_taken),
    .pipe_1     (pipe_1),
    .pipe_2     (pipe_2),
    .pipe_3     (pipe_3),
    .coin       (coin),
    .score_tick (score_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic b;
    b = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {b, v[15:1]};
  endfunction

  // Reference random source, reset and clocked like the design's
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  // Count every cycle the score pulse is high
  always @(negedge clk) begin
    if (score_tick === 1'b1) n_score <= n_score + 1;
  end

  function automatic int exp_h(input logic [15:0] l, input int g);
    int h;
    h = 60 + int'(l[7:0]);
    if (h + g > 440) h = 440 - g;
    return h;
  endfunction

  function automatic logic [31:0] pipe_word(input int h, input int x, input int g);
    return {4'b0000, 8'(g), 10'(x), 10'(h)};
  endfunction

  function automatic logic [31:0] coin_word(input logic v, input int y, input int x);
    return {v, 11'b0, 10'(y), 10'(x)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l0, l1, l2, la, lb, nxt;
    int          ha, hb, h1, h2, k;

    rst = 1'b1; start = 1'b0; run = 1'b0; frame_tick = 1'b0;
    gap_cfg = 8'd100; coin_taken = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_pipe1", pipe_1, 32'h0);
    check("rst_pipe2", pipe_2, 32'h0);
    check("rst_pipe3", pipe_3, 32'h0);
    check("rst_coin",  coin,   32'h0);
    check("rst_score", {31'b0, score_tick}, 32'h0);
    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("rst_lfsr",  {16'h0, dut.w_lfsr}, 32'h0000ACE1);

    rst = 1'b0; run = 1'b1;
    tick();
    check("idle_no_start", 32'(dut.r_state), 32'(ST_IDLE));

    // Start and three INIT cycles
    start = 1'b1; tick(); start = 1'b0;
    check("state_init", 32'(dut.r_state), 32'(ST_INIT));
    l0 = m_lfsr; tick();
    l1 = m_lfsr; tick();
    l2 = m_lfsr; tick();
    h1 = exp_h(l1, 100);
    h2 = exp_h(l2, 100);
    check("state_run", 32'(dut.r_state), 32'(ST_RUN));
    check("init_pipe1", pipe_1, pipe_word(exp_h(l0, 100), 448, 100));
    check("init_pipe2", pipe_2, pipe_word(h1, 672, 100));
    check("init_pipe3", pipe_3, pipe_word(h2, 896, 100));
    check("init_coin",  coin, 32'h0);

    // Scroll slot 0 down to the crossing point
    repeat (214) frame();
    check("x_at_20", {22'b0, pipe_1[19:10]}, 32'd20);
    check("score_none_yet", 32'(n_score), 32'd0);
    frame();
    check("x_at_18", {22'b0, pipe_1[19:10]}, 32'd18);
    check("score_pulse", {31'b0, score_tick}, 32'd1);
    tick();
    check("score_one_cycle", {31'b0, score_tick}, 32'd0);
    repeat (9) frame();
    check("x_at_0", {22'b0, pipe_1[19:10]}, 32'd0);
    check("score_count_1", 32'(n_score), 32'd1);

    // Recycle of slot 0
    la = m_lfsr;
    ha = exp_h(la, 100);
    frame();
    check("recycle_pipe1", pipe_1, pipe_word(ha, 670, 100));
    check("recycle_h_range", {31'b0, (ha >= 60) && (ha <= 340)}, 32'd1);
    check("recycle_pipe2", pipe_2, pipe_word(h1, 222, 100));
    check("recycle_pipe3", pipe_3, pipe_word(h2, 446, 100));
    check("recycle_coin", coin, coin_word(la[8], ha + 42, 687));

    // HOLD freezes everything
    run = 1'b0; tick();
    check("state_hold", 32'(dut.r_state), 32'(ST_HOLD));
    repeat (5) frame();
    check("hold_pipe1", pipe_1, pipe_word(ha, 670, 100));
    check("hold_pipe2", pipe_2, pipe_word(h1, 222, 100));
    check("hold_coin",  coin, coin_word(la[8], ha + 42, 687));
    run = 1'b1; tick();
    check("state_resume", 32'(dut.r_state), 32'(ST_RUN));
    frame();
    check("resume_pipe1", pipe_1, pipe_word(ha, 668, 100));
    check("resume_pipe2", pipe_2, pipe_word(h1, 220, 100));
    check("resume_pipe3", pipe_3, pipe_word(h2, 444, 100));
    check("resume_coin",  coin, coin_word(la[8], ha + 42, 685));

    // Slot 1 down to zero (crosses the bird on the way)
    repeat (110) frame();
    check("slot1_at_0", {22'b0, pipe_2[19:10]}, 32'd0);
    check("score_count_2", 32'(n_score), 32'd2);

    // Wait for a visible-coin draw, then recycle together with a pickup
    k = 0;
    while (m_lfsr[8] !== 1'b1 && k < 1000) begin
      tick();
      k++;
    end
    check("wait_lfsr8", {31'b0, k < 1000}, 32'd1);
    lb = m_lfsr;
    hb = exp_h(lb, 100);
    frame_tick = 1'b1; coin_taken = 1'b1;
    tick();
    frame_tick = 1'b0; coin_taken = 1'b0;
    check("spawn_pipe2", pipe_2, pipe_word(hb, 670, 100));
    check("spawn_beats_take", coin, coin_word(1'b1, hb + 42, 687));

    // Pickup alone hides the coin
    coin_taken = 1'b1; tick(); coin_taken = 1'b0;
    check("coin_taken", coin, coin_word(1'b0, hb + 42, 687));

    // Height clamp: random byte 255 with a 200-pixel opening
    gap_cfg = 8'd200;
    k = 0;
    nxt = lfsr_next(m_lfsr);
    while (nxt[7:0] != 8'hFF && k < 40000) begin
      tick();
      k++;
      nxt = lfsr_next(m_lfsr);
    end
    check("wait_lfsr_ff", {31'b0, k < 40000}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("clamp_pipe1", pipe_1, pipe_word(240, 448, 200));
    check("init_clears_coin", coin, 32'h0);
    tick(); tick();
    check("clamp_state_run", 32'(dut.r_state), 32'(ST_RUN));

    // Asynchronous reset in the middle of play
    frame();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_pipe1", pipe_1, 32'h0);
    check("async_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    tick();
    rst = 1'b0; run = 1'b1;
    repeat (3) frame();
    check("post_rst_idle",  32'(dut.r_state), 32'(ST_IDLE));
    check("post_rst_pipe2", pipe_2, 32'h0);
    check("post_rst_coin",  coin, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 SHALL have parameter STEP, default 2, pixels each pipe and coin moves left per frame.
REQ-002 SHALL have parameter SPACING, default 224, horizontal pitch between consecutive pipes.
REQ-003 SHALL have parameter PIPE_W, default 50, pipe width in pixels.
REQ-004 SHALL have parameter BIRD_X, default 70, x position of the character's left edge.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse requesting a new game layout.
REQ-008 SHALL have port run, input, 1 bit: level signal, high while the game is in play.
REQ-009 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-010 SHALL have port gap_cfg, input, 8 bits: vertical opening between the two pipes of a group.
REQ-011 SHALL have port coin_taken, input, 1 bit: one-cycle pulse when the character hits the coin.
REQ-012 SHALL have ports pipe_1, pipe_2 and pipe_3, outputs, 32 bits each: [9:0] top-pipe height, [19:10] x, [27:20] gap, [31:28] zero.
REQ-013 SHALL have port coin, output, 32 bits: [9:0] x, [19:10] y, [30:20] zero, [31] visible.
REQ-014 SHALL have port score_tick, output, 1 bit: one-cycle pulse each time a pipe clears the character.

Function
REQ-015 SHALL implement the states IDLE, INIT, RUN and HOLD.
REQ-016 SHALL go from IDLE to INIT on start, from INIT to RUN after exactly 3 cycles, from RUN to HOLD when run=0, and from HOLD to RUN when run=1.
REQ-017 SHALL enter INIT on start from any state, with start taking priority over all other inputs that cycle.
REQ-018 In INIT, SHALL load slot k (k=0,1,2, one slot per cycle) with x = 448 + k*SPACING, a new height (REQ-020) and gap = gap_cfg.
REQ-019 In INIT, SHALL clear coin and score_tick.
REQ-020 SHALL compute a new height h = 60 + lfsr[7:0], and if h + gap_cfg > 440 SHALL replace it with h = 440 - gap_cfg; all arithmetic is 10-bit unsigned.
REQ-021 SHALL run a 16-bit LFSR every clock in all states, seed 16'hACE1, taps 16,14,13,11, never reaching zero.
REQ-022 In RUN, on frame_tick, SHALL decrement every slot x by STEP; outputs are registered and update the cycle after frame_tick.
REQ-023 SHALL recycle a slot when x < STEP at a frame_tick: x becomes x + 3*SPACING - STEP, with a new height and gap = gap_cfg latched at that moment.
REQ-024 SHALL recycle at most one slot per frame; if two slots qualify in the same frame, the lower-index slot goes first and the other waits for the next frame.
REQ-025 On a recycle, SHALL place the coin at x = new_x + 17 and y = h + gap/2 - 8, with visible = lfsr[8].
REQ-026 In RUN, SHALL move the coin x by -STEP on each frame_tick and clear visible when coin x < STEP.
REQ-027 On coin_taken, SHALL clear coin[31] in the next cycle in any state.
REQ-028 If coin_taken and a coin-spawning recycle occur in the same cycle, the new coin SHALL win.
REQ-029 SHALL pulse score_tick for exactly one cycle when a slot moves from x+PIPE_W >= BIRD_X to x+PIPE_W < BIRD_X.
REQ-030 If two slots cross in the same frame, score_tick SHALL still pulse only once.
REQ-031 In HOLD and IDLE, frame_tick SHALL be ignored and all outputs held.

Reset
REQ-032 While rst=1, SHALL force state IDLE, pipe_1, pipe_2, pipe_3 and coin to 32'h0, score_tick to 0 and the LFSR to 16'hACE1, immediately and independent of clk.
REQ-033 Asserting rst mid-RUN SHALL discard the layout; after reset is released, only start leaves IDLE.

Structure
REQ-034 SHALL take the state enum, the pipe and coin field offsets, and the constants 60/440/448 from the shared package flappy_pkg.
REQ-035 SHALL instantiate one sub-module, lfsr16, holding the free-running LFSR.

Verification
REQ-036 Bench SHALL check: reset, then start, then 3 cycles -> state RUN; pipe x values 448/672/896; gap = gap_cfg; coin = 0.
REQ-037 Bench SHALL check: RUN with 224 frame_ticks, STEP=2 -> slot0 x at 0; the next tick recycles it to 670 with a new height in 60..440-gap.
REQ-038 Bench SHALL check: gap_cfg=200 with lfsr[7:0]=255 -> height clamped to 240.
REQ-039 Bench SHALL check: slot x stepping from 20 to 18 -> exactly one score_tick pulse; no pulse on the next frames.
REQ-040 Bench SHALL check: run=0 with frame_ticks -> outputs frozen; run=1 -> motion resumes from the same x.
REQ-041 Bench SHALL check: coin_taken in the same cycle as a recycle with lfsr[8]=1 -> coin[31]=1 at the new position.
